// File: rtl/ara_uart_apb_pkg.sv
// Shared types and width defaults for the UART APB arbiter slice.
package ara_uart_apb_pkg;

   localparam int unsigned ApbAddrWidth = 32;
   localparam int unsigned ApbDataWidth = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   typedef struct packed {
      logic [ApbAddrWidth-1:0] paddr;
      logic                    pwrite;
      logic [ApbDataWidth-1:0] pwdata;
   } apb_req_t;

   typedef struct packed {
      logic [ApbDataWidth-1:0] prdata;
      logic                    pslverr;
   } apb_rsp_t;

   // Index width for an n-entry vector; a single entry still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ara_uart_apb_arbiter_if.sv
// Requester-side bus and APB3 bus of the UART arbiter.

// Requester side: masters present requests, the arbiter grants and responds.
interface ara_uart_apb_arbiter_if #(
   parameter int unsigned NrReq     = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) ();
   logic [NrReq-1:0]                req;
   logic [NrReq-1:0]                we;
   logic [NrReq-1:0][AddrWidth-1:0] addr;
   logic [NrReq-1:0][DataWidth-1:0] wdata;
   logic [NrReq-1:0]                gnt;
   logic [NrReq-1:0]                rsp_valid;
   logic [DataWidth-1:0]            rsp_rdata;
   logic                            rsp_err;

   modport master (output req, we, addr, wdata, input gnt, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input req, we, addr, wdata, output gnt, rsp_valid, rsp_rdata, rsp_err);
endinterface

// APB3 side: the arbiter is the master, the UART is the slave.
interface ara_uart_apb_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) ();
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [AddrWidth-1:0] paddr;
   logic [DataWidth-1:0] pwdata;
   logic [DataWidth-1:0] prdata;
   logic                 pready;
   logic                 pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
   modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/ara_rr_pick.sv
// Round-robin picker: first requesting index at or after ptr, wrapping modulo NrReq.
module ara_rr_pick #(
   parameter int unsigned NrReq = 2,
   parameter int unsigned IdxW  = 1
) (
   input  logic [NrReq-1:0] req,
   input  logic [IdxW-1:0]  ptr,
   output logic [NrReq-1:0] gnt,
   output logic [IdxW-1:0]  idx,
   output logic             valid
);

   logic [IdxW-1:0] cand;

   // Scan from the pointer and keep the first hit.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int unsigned off = 0; off < NrReq; off++) begin
         cand = IdxW'((32'(ptr) + off) % NrReq);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ara_uart_apb_arbiter.sv
// Shares one APB3 UART slave among NrReq request/response masters:
// round-robin grant, one transfer in flight, PREADY watchdog.
module ara_uart_apb_arbiter
   import ara_uart_apb_pkg::*;
#(
   parameter int unsigned NrReq         = 2,
   parameter int unsigned AddrWidth     = ApbAddrWidth,
   parameter int unsigned DataWidth     = ApbDataWidth,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   ara_uart_apb_arbiter_if.slave  req_bus,
   ara_uart_apb_if.master         apb
);

   localparam int unsigned IdxW  = idx_width(NrReq);
   localparam int unsigned WdogW = $clog2(TimeoutCycles);

   state_e               state;
   logic [IdxW-1:0]      ptr;
   logic [IdxW-1:0]      owner;
   logic [WdogW-1:0]     wdog;
   logic                 psel_q;
   logic                 penable_q;
   logic                 pwrite_q;
   logic [AddrWidth-1:0] paddr_q;
   logic [DataWidth-1:0] pwdata_q;
   logic [NrReq-1:0]     rsp_valid_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 err_q;

   logic [NrReq-1:0]     pick_gnt;
   logic [IdxW-1:0]      pick_idx;
   logic                 pick_valid;
   logic                 wdog_expired;
   logic                 access_end;

   ara_rr_pick #(
      .NrReq (NrReq),
      .IdxW  (IdxW)
   ) u_pick (
      .req   (req_bus.req),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Grant is a same-cycle decision in IDLE; held off while reset is asserted.
   assign req_bus.gnt = (state == IDLE && rst_ni) ? pick_gnt : '0;

   // An ACCESS cycle ends on pready, or on the last watchdog cycle.
   assign wdog_expired = (wdog == WdogW'(TimeoutCycles - 1));
   assign access_end   = (state == ACCESS) && (apb.pready || wdog_expired);

   // Transfer sequencer: latch on grant, drive SETUP/ACCESS, register the response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         wdog        <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner    <= pick_idx;
                  ptr      <= IdxW'((32'(pick_idx) + 32'd1) % NrReq);
                  paddr_q  <= req_bus.addr[pick_idx];
                  pwrite_q <= req_bus.we[pick_idx];
                  pwdata_q <= req_bus.we[pick_idx] ? req_bus.wdata[pick_idx] : '0;
                  psel_q   <= 1'b1;
                  wdog     <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (access_end) begin
                  // A timeout drops psel without pready and reports an error.
                  rdata_q            <= (apb.pready && !pwrite_q) ? apb.prdata : '0;
                  err_q              <= apb.pready ? apb.pslverr : 1'b1;
                  rsp_valid_q[owner] <= 1'b1;
                  psel_q             <= 1'b0;
                  penable_q          <= 1'b0;
                  pwrite_q           <= 1'b0;
                  paddr_q            <= '0;
                  pwdata_q           <= '0;
                  state              <= IDLE;
               end else begin
                  wdog <= wdog + WdogW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign apb.psel          = psel_q;
   assign apb.penable       = penable_q;
   assign apb.pwrite        = pwrite_q;
   assign apb.paddr         = paddr_q;
   assign apb.pwdata        = pwdata_q;
   assign req_bus.rsp_valid = rsp_valid_q;
   assign req_bus.rsp_rdata = rdata_q;
   assign req_bus.rsp_err   = err_q;

endmodule
